// File: rtl/branch_resolve_unit.sv
// Resolves control-flow instructions in EX against the IF prediction and
// issues a registered redirect/flush, a predictor update record and counters.
module branch_resolve_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      pc4_i,
   input  logic             is_conditional_branch_i,
   input  logic             is_jal_i,
   input  logic             is_jalr_i,
   input  logic             predict_taken_i,
   input  logic [31:0]      predict_pc_i,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      rs1_i,
   input  logic [31:0]      rs2_i,
   input  logic [31:0]      imm_i,
   output logic             br_taken_o,
   output logic [31:0]      br_target_o,
   output logic             flush_o,
   output logic             upd_valid_o,
   output logic [31:0]      upd_pc_o,
   output logic             upd_taken_o,
   output logic [31:0]      upd_target_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispredict_cnt_o
);

   typedef enum logic {NORMAL, SHADOW} state_t;

   state_t            state_q, state_d;
   logic [31:0]       brTarget_q, brTarget_d;
   logic              updValid_q, updValid_d;
   logic [31:0]       updPc_q, updPc_d;
   logic              updTaken_q, updTaken_d;
   logic [31:0]       updTarget_q, updTarget_d;
   logic [CNT_W-1:0]  branchCnt_q, branchCnt_d;
   logic [CNT_W-1:0]  mispCnt_q, mispCnt_d;

   logic              isCtrl, eval, condTaken, taken, mispredict;
   logic [31:0]       jalrSum, target, actualNext, predNext;

   assign isCtrl = is_conditional_branch_i | is_jal_i | is_jalr_i;
   assign eval   = valid_i & ~stall_i & (state_q == NORMAL) & isCtrl;

   always_comb begin
      condTaken = 1'b0;
      case (funct3_i)
         3'b000:  condTaken = (rs1_i == rs2_i);
         3'b001:  condTaken = (rs1_i != rs2_i);
         3'b100:  condTaken = ($signed(rs1_i) <  $signed(rs2_i));
         3'b101:  condTaken = ($signed(rs1_i) >= $signed(rs2_i));
         3'b110:  condTaken = (rs1_i <  rs2_i);
         3'b111:  condTaken = (rs1_i >= rs2_i);
         default: condTaken = 1'b0;
      endcase
   end

   // Mispredict is judged on the next PC, so a "taken" guess that points at
   // pc4 is still correct for a fall-through branch.
   assign jalrSum    = rs1_i + imm_i;
   assign target     = is_jalr_i ? {jalrSum[31:1], 1'b0} : (pc_i + imm_i);
   assign taken      = is_jal_i | is_jalr_i | (is_conditional_branch_i & condTaken);
   assign actualNext = taken ? target : pc4_i;
   assign predNext   = predict_taken_i ? predict_pc_i : pc4_i;
   assign mispredict = eval & (actualNext != predNext);

   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL:  if (mispredict) state_d = SHADOW;
         SHADOW:  state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   always_comb begin
      brTarget_d  = brTarget_q;
      updValid_d  = eval;
      updPc_d     = updPc_q;
      updTaken_d  = updTaken_q;
      updTarget_d = updTarget_q;
      branchCnt_d = branchCnt_q;
      mispCnt_d   = mispCnt_q;
      if (eval) begin
         updPc_d     = pc_i;
         updTaken_d  = taken;
         updTarget_d = target;
         branchCnt_d = branchCnt_q + CNT_W'(1);
      end
      if (mispredict) begin
         brTarget_d = actualNext;
         mispCnt_d  = mispCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= NORMAL;
         brTarget_q  <= '0;
         updValid_q  <= 1'b0;
         updPc_q     <= '0;
         updTaken_q  <= 1'b0;
         updTarget_q <= '0;
         branchCnt_q <= '0;
         mispCnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         brTarget_q  <= brTarget_d;
         updValid_q  <= updValid_d;
         updPc_q     <= updPc_d;
         updTaken_q  <= updTaken_d;
         updTarget_q <= updTarget_d;
         branchCnt_q <= branchCnt_d;
         mispCnt_q   <= mispCnt_d;
      end
   end

   assign br_taken_o       = (state_q == SHADOW);
   assign flush_o          = (state_q == SHADOW);
   assign br_target_o      = brTarget_q;
   assign upd_valid_o      = updValid_q;
   assign upd_pc_o         = updPc_q;
   assign upd_taken_o      = updTaken_q;
   assign upd_target_o     = updTarget_q;
   assign branch_cnt_o     = branchCnt_q;
   assign mispredict_cnt_o = mispCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, corner
// sequences and randomized traffic against a next-PC reference model.
module tb_branch_resolve_unit;

   localparam int CNT_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid, stall;
   logic [31:0]       pc, pc4, predPc, rs1, rs2, imm;
   logic              isCond, isJal, isJalr, predTaken;
   logic [2:0]        funct3;
   logic              brTaken, flush, updValid, updTaken;
   logic [31:0]       brTarget, updPc, updTarget;
   logic [CNT_W-1:0]  branchCnt, mispCnt;

   int                tests = 0;
   int                errors = 0;

   logic              mShadow = 1'b0;
   logic              expBrTaken, expUpdValid, expUpdTaken;
   logic [31:0]       expBrTarget, expUpdPc, expUpdTarget;
   logic [CNT_W-1:0]  expBranchCnt, expMispCnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.CNT_W(CNT_W)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .valid_i                 (valid),
      .stall_i                 (stall),
      .pc_i                    (pc),
      .pc4_i                   (pc4),
      .is_conditional_branch_i (isCond),
      .is_jal_i                (isJal),
      .is_jalr_i               (isJalr),
      .predict_taken_i         (predTaken),
      .predict_pc_i            (predPc),
      .funct3_i                (funct3),
      .rs1_i                   (rs1),
      .rs2_i                   (rs2),
      .imm_i                   (imm),
      .br_taken_o              (brTaken),
      .br_target_o             (brTarget),
      .flush_o                 (flush),
      .upd_valid_o             (updValid),
      .upd_pc_o                (updPc),
      .upd_taken_o             (updTaken),
      .upd_target_o            (updTarget),
      .branch_cnt_o            (branchCnt),
      .mispredict_cnt_o        (mispCnt)
   );

   typedef struct {
      string       name;
      int          kind;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        predTaken;
      logic [31:0] predPc;
      logic        expRedirect;
      logic [31:0] expRedTarget;
      logic        expTaken;
      logic [31:0] expUpdTarget;
   } vec_t;

   vec_t vecs[12];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural outcome straight from the ISA rules.
   task automatic refResolve(output logic tk, output logic [31:0] tgt);
      logic [31:0] s;
      tk  = 1'b0;
      tgt = pc + imm;
      if (isJal) tk = 1'b1;
      else if (isJalr) begin
         s      = rs1 + imm;
         s[0]   = 1'b0;
         tgt    = s;
         tk     = 1'b1;
      end else if (isCond) begin
         case (funct3)
            3'd0: tk = (rs1 == rs2);
            3'd1: tk = (rs1 != rs2);
            3'd4: tk = (int'(rs1) <  int'(rs2));
            3'd5: tk = (int'(rs1) >= int'(rs2));
            3'd6: tk = ({1'b0, rs1} <  {1'b0, rs2});
            3'd7: tk = ({1'b0, rs1} >= {1'b0, rs2});
            default: tk = 1'b0;
         endcase
      end
   endtask

   task automatic checkOutput();
      checkVal("br_taken",   32'(brTaken),   32'(expBrTaken));
      checkVal("flush",      32'(flush),     32'(expBrTaken));
      checkVal("br_target",  brTarget,       expBrTarget);
      checkVal("upd_valid",  32'(updValid),  32'(expUpdValid));
      checkVal("upd_pc",     updPc,          expUpdPc);
      checkVal("upd_taken",  32'(updTaken),  32'(expUpdTaken));
      checkVal("upd_target", updTarget,      expUpdTarget);
      checkVal("branch_cnt", 32'(branchCnt), 32'(expBranchCnt));
      checkVal("misp_cnt",   32'(mispCnt),   32'(expMispCnt));
   endtask

   // Predict what the unit shows after the coming edge, then clock and compare.
   task automatic applyStimulus();
      logic tk, doEval, miss;
      logic [31:0] tgt, actNext, guess;
      if (rst) begin
         mShadow = 1'b0; expBrTaken = 1'b0; expBrTarget = '0;
         expUpdValid = 1'b0; expUpdPc = '0; expUpdTaken = 1'b0; expUpdTarget = '0;
         expBranchCnt = '0; expMispCnt = '0;
      end else begin
         refResolve(tk, tgt);
         actNext = tk ? tgt : pc4;
         guess   = predTaken ? predPc : pc4;
         doEval  = !mShadow && valid && !stall && (isCond || isJal || isJalr);
         miss    = doEval && (actNext != guess);
         expBrTaken  = miss;
         expUpdValid = doEval;
         if (miss) begin
            expBrTarget = actNext;
            expMispCnt  = expMispCnt + 1'b1;
         end
         if (doEval) begin
            expUpdPc     = pc;
            expUpdTaken  = tk;
            expUpdTarget = tgt;
            expBranchCnt = expBranchCnt + 1'b1;
         end
         mShadow = miss;
      end
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic setInstr(input int kind, input logic [2:0] f3, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                           input logic pt, input logic [31:0] ppc);
      isCond = (kind == 0); isJal = (kind == 1); isJalr = (kind == 2);
      funct3 = f3; pc = p; pc4 = p + 32'd4; imm = im; rs1 = a; rs2 = b;
      predTaken = pt; predPc = ppc;
   endtask

   initial begin
      logic [7:0]  bc0, mc0;
      logic [11:0] r12;
      logic        tk;
      logic [31:0] tgt;
      int          k, p;

      vecs[0]  = '{"beq_misp",    0, 3'd0, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0,
                   1'b1, 32'h140, 1'b1, 32'h140};
      vecs[1]  = '{"bne_ok",      0, 3'd1, 32'h200, 32'h20, 32'd1, 32'd2, 1'b1, 32'h220,
                   1'b0, 32'h0,   1'b1, 32'h220};
      vecs[2]  = '{"jalr_lsb",    2, 3'd0, 32'h300, 32'h0,  32'h2003, 32'd0, 1'b1, 32'h2000,
                   1'b1, 32'h2002, 1'b1, 32'h2002};
      vecs[3]  = '{"jalr_ok",     2, 3'd0, 32'h300, 32'h0,  32'h2003, 32'd0, 1'b1, 32'h2002,
                   1'b0, 32'h0,   1'b1, 32'h2002};
      vecs[4]  = '{"blt_signed",  0, 3'd4, 32'h400, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h410,
                   1'b0, 32'h0,   1'b1, 32'h410};
      vecs[5]  = '{"bltu_nt",     0, 3'd6, 32'h400, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,
                   1'b0, 32'h0,   1'b0, 32'h410};
      vecs[6]  = '{"bgeu_t",      0, 3'd7, 32'h400, 32'h10, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0,
                   1'b1, 32'h410, 1'b1, 32'h410};
      vecs[7]  = '{"f3_010",      0, 3'd2, 32'h400, 32'h10, 32'd5, 32'd5, 1'b1, 32'h410,
                   1'b1, 32'h404, 1'b0, 32'h410};
      vecs[8]  = '{"beq_pt_pc4",  0, 3'd0, 32'h500, 32'h80, 32'd1, 32'd2, 1'b1, 32'h504,
                   1'b0, 32'h0,   1'b0, 32'h580};
      vecs[9]  = '{"jal_back",    1, 3'd0, 32'h600, 32'hFFFFFFF0, 32'd0, 32'd0, 1'b0, 32'h0,
                   1'b1, 32'h5F0, 1'b1, 32'h5F0};
      vecs[10] = '{"bge_signed",  0, 3'd5, 32'h700, 32'h8,  32'd1, 32'hFFFFFFFF, 1'b1, 32'h708,
                   1'b0, 32'h0,   1'b1, 32'h708};
      vecs[11] = '{"jal_wrap",    1, 3'd0, 32'hFFFFFFF0, 32'h20, 32'd0, 32'd0, 1'b1, 32'h10,
                   1'b0, 32'h0,   1'b1, 32'h10};

      rst = 1'b1; valid = 1'b0; stall = 1'b0;
      setInstr(3, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      applyStimulus();
      applyStimulus();
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         setInstr(vecs[i].kind, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].rs1,
                  vecs[i].rs2, vecs[i].predTaken, vecs[i].predPc);
         valid = 1'b1;
         applyStimulus();
         checkVal({vecs[i].name, "_redirect"}, 32'(brTaken), 32'(vecs[i].expRedirect));
         checkVal({vecs[i].name, "_upd_valid"}, 32'(updValid), 32'd1);
         checkVal({vecs[i].name, "_upd_taken"}, 32'(updTaken), 32'(vecs[i].expTaken));
         checkVal({vecs[i].name, "_upd_target"}, updTarget, vecs[i].expUpdTarget);
         if (vecs[i].expRedirect)
            checkVal({vecs[i].name, "_br_target"}, brTarget, vecs[i].expRedTarget);
         if (i == 0) begin
            checkVal("first_branch_cnt", 32'(branchCnt), 32'd1);
            checkVal("first_misp_cnt",   32'(mispCnt),   32'd1);
         end
         valid = 1'b0;
         applyStimulus();
         checkVal({vecs[i].name, "_pulse_end"}, 32'(brTaken), 32'd0);
      end

      // Second mispredicting branch lands in the shadow cycle and must vanish.
      bc0 = expBranchCnt; mc0 = expMispCnt;
      setInstr(0, 3'd0, 32'h800, 32'h40, 32'd3, 32'd3, 1'b0, 32'h0);
      valid = 1'b1;
      applyStimulus();
      checkVal("shadow_first_redirect", 32'(brTaken), 32'd1);
      setInstr(0, 3'd0, 32'h900, 32'h40, 32'd7, 32'd7, 1'b0, 32'h0);
      applyStimulus();
      checkVal("shadow_second_redirect", 32'(brTaken), 32'd0);
      checkVal("shadow_upd_valid", 32'(updValid), 32'd0);
      checkVal("shadow_branch_cnt", 32'(branchCnt), 32'(bc0 + 8'd1));
      checkVal("shadow_misp_cnt", 32'(mispCnt), 32'(mc0 + 8'd1));
      valid = 1'b0;
      applyStimulus();
      checkVal("shadow_after", 32'(brTaken), 32'd0);

      bc0 = expBranchCnt;
      setInstr(0, 3'd1, 32'hA00, 32'h20, 32'd1, 32'd2, 1'b1, 32'hA20);
      valid = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkVal("stall_no_upd", 32'(updValid), 32'd0);
      end
      stall = 1'b0;
      applyStimulus();
      checkVal("stall_release_upd", 32'(updValid), 32'd1);
      checkVal("stall_release_cnt", 32'(branchCnt), 32'(bc0 + 8'd1));
      valid = 1'b0;
      applyStimulus();
      checkVal("stall_once", 32'(updValid), 32'd0);

      setInstr(0, 3'd0, 32'hB00, 32'h40, 32'd4, 32'd4, 1'b0, 32'h0);
      valid = 1'b1;
      applyStimulus();
      valid = 1'b0; rst = 1'b1;
      applyStimulus();
      checkVal("rst_shadow_taken", 32'(brTaken), 32'd0);
      checkVal("rst_shadow_target", brTarget, 32'd0);
      checkVal("rst_shadow_cnt", 32'(branchCnt), 32'd0);
      rst = 1'b0;

      setInstr(1, 3'd0, 32'hC00, 32'h100, 32'd0, 32'd0, 1'b1, 32'hD00);
      valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         applyStimulus();
         if (i == 254) checkVal("branch_cnt_max", 32'(branchCnt), 32'd255);
      end
      checkVal("branch_cnt_wrap", 32'(branchCnt), 32'd0);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      predTaken = 1'b0;
      for (int i = 0; i < 511; i++) applyStimulus();
      checkVal("misp_cnt_wrap", 32'(mispCnt), 32'd0);
      checkVal("misp_wrap_redirect", 32'(brTaken), 32'd1);

      for (int n = 0; n < 1500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 4) == 0);
         k     = $urandom_range(0, 3);
         r12   = 12'($urandom);
         setInstr(k, 3'($urandom_range(0, 7)), $urandom & 32'hFFFFFFFC,
                  {{20{r12[11]}}, r12}, $urandom, $urandom, 1'b0, $urandom);
         if ($urandom_range(0, 3) == 0) rs2 = rs1;
         p = $urandom_range(0, 2);
         if (p == 1) begin
            refResolve(tk, tgt);
            predTaken = tk;
            predPc    = tk ? tgt : $urandom;
         end else if (p == 2) begin
            predTaken = 1'b1;
            predPc    = ($urandom_range(0, 1) == 0) ? pc4 : $urandom;
         end
         applyStimulus();
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
